// File: rtl/user_obi_mailbox.sv
// OBI mailbox in the user domain: CPU writes feed a TX stream FIFO, an RX stream
// FIFO is drained by CPU reads, and irq_o flags pending RX data when enabled.
module user_obi_mailbox #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               obi_req_i,
    output logic               obi_gnt_o,
    input  logic [31:0]        obi_addr_i,
    input  logic               obi_we_i,
    input  logic [3:0]         obi_be_i,
    input  logic [31:0]        obi_wdata_i,
    input  logic [IdWidth-1:0] obi_aid_i,
    output logic               obi_rvalid_o,
    output logic [31:0]        obi_rdata_o,
    output logic [IdWidth-1:0] obi_rid_o,
    output logic               obi_err_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic [31:0]        tx_data_o,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    input  logic [31:0]        rx_data_i,
    output logic               irq_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned LvlWidth = $clog2(Depth + 1);
    localparam logic [LvlWidth-1:0] LvlFull = LvlWidth'(Depth);

    typedef enum logic [1:0] {
        SelData,
        SelStatus,
        SelCtrl,
        SelNone
    } sel_e;

    logic [31:0]         tx_mem [Depth];
    logic [31:0]         rx_mem [Depth];
    logic [PtrWidth-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [LvlWidth-1:0] tx_lvl, rx_lvl, tx_lvl_next, rx_lvl_next;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                tx_push, tx_pop, rx_push, rx_pop;
    logic                tx_clr, rx_clr;
    logic                irq_en, irq_en_next;
    logic                rsp_err;
    logic [31:0]         rsp_rdata;
    logic [31:0]         status;
    sel_e                sel;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{obi_addr_i[31:12], obi_addr_i[1:0]};

    assign obi_gnt_o = 1'b1;

    assign tx_full  = (tx_lvl == LvlFull);
    assign tx_empty = (tx_lvl == '0);
    assign rx_full  = (rx_lvl == LvlFull);
    assign rx_empty = (rx_lvl == '0);

    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_mem[tx_rd];
    assign rx_ready_o = !rx_full;

    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign rx_push = rx_valid_i & rx_ready_o;

    assign status = {8'h00, 8'(rx_lvl), 8'(tx_lvl), 4'h0, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        unique case (obi_addr_i[11:2])
            10'd0:   sel = SelData;
            10'd1:   sel = SelStatus;
            10'd2:   sel = SelCtrl;
            default: sel = SelNone;
        endcase
    end

    // Fullness/emptiness checks use the pre-cycle levels, so a same-cycle stream
    // pop/push never rescues an OBI access that would otherwise be refused.
    always_comb begin
        tx_push     = 1'b0;
        rx_pop      = 1'b0;
        tx_clr      = 1'b0;
        rx_clr      = 1'b0;
        irq_en_next = irq_en;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        if (obi_req_i) begin
            unique case (sel)
                SelData: begin
                    if (obi_we_i) begin
                        if (obi_be_i != 4'hF || tx_full) rsp_err = 1'b1;
                        else                             tx_push = 1'b1;
                    end else begin
                        if (rx_empty) begin
                            rsp_err = 1'b1;
                        end else begin
                            rx_pop    = 1'b1;
                            rsp_rdata = rx_mem[rx_rd];
                        end
                    end
                end
                SelStatus: begin
                    if (obi_we_i) rsp_err   = 1'b1;
                    else          rsp_rdata = status;
                end
                SelCtrl: begin
                    if (obi_we_i) begin
                        tx_clr      = obi_wdata_i[0];
                        rx_clr      = obi_wdata_i[1];
                        irq_en_next = obi_wdata_i[8];
                    end else begin
                        rsp_rdata = {23'h0, irq_en, 8'h00};
                    end
                end
                default: rsp_err = 1'b1;
            endcase
        end
    end

    assign tx_lvl_next = tx_clr ? '0 : tx_lvl + LvlWidth'(tx_push) - LvlWidth'(tx_pop);
    assign rx_lvl_next = rx_clr ? '0 : rx_lvl + LvlWidth'(rx_push) - LvlWidth'(rx_pop);

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr] <= obi_wdata_i;
        if (rx_push) rx_mem[rx_wr] <= rx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr        <= '0;
            tx_rd        <= '0;
            rx_wr        <= '0;
            rx_rd        <= '0;
            tx_lvl       <= '0;
            rx_lvl       <= '0;
            irq_en       <= 1'b0;
            irq_o        <= 1'b0;
            obi_rvalid_o <= 1'b0;
            obi_err_o    <= 1'b0;
            obi_rdata_o  <= '0;
            obi_rid_o    <= '0;
        end else begin
            tx_lvl <= tx_lvl_next;
            rx_lvl <= rx_lvl_next;
            // A clear discards any handshake completing in the same cycle.
            if (tx_clr) begin
                tx_wr <= '0;
                tx_rd <= '0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + PtrWidth'(1);
                if (tx_pop)  tx_rd <= tx_rd + PtrWidth'(1);
            end
            if (rx_clr) begin
                rx_wr <= '0;
                rx_rd <= '0;
            end else begin
                if (rx_push) rx_wr <= rx_wr + PtrWidth'(1);
                if (rx_pop)  rx_rd <= rx_rd + PtrWidth'(1);
            end
            irq_en       <= irq_en_next;
            irq_o        <= irq_en_next & (rx_lvl_next != '0);
            obi_rvalid_o <= obi_req_i;
            obi_err_o    <= obi_req_i & rsp_err;
            obi_rdata_o  <= obi_req_i ? rsp_rdata : '0;
            obi_rid_o    <= obi_req_i ? obi_aid_i : '0;
        end
    end
endmodule

// File: tb/tb_user_obi_mailbox.sv
// Bench for user_obi_mailbox: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_user_obi_mailbox;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] wdata = '0;
    logic [0:0]  aid = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] rx_data = '0;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    user_obi_mailbox #(.Depth(DEPTH), .IdWidth(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
        .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid),
        .obi_rvalid_o(rvalid), .obi_rdata_o(rdata), .obi_rid_o(rid), .obi_err_o(err),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues updated from the inputs seen at each edge.
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    bit          m_irq_en;
    bit          m_ready = 0;
    bit          e_rvalid, e_err, e_irq;
    logic [31:0] e_rdata;
    logic [0:0]  e_rid;

    always @(posedge clk) begin
        bit tpop, rpush, tpush, rpop, tclr, rclr, terr;
        logic [31:0] rd;
        int unsigned off;
        m_ready = 1;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_irq_en = 0;
            e_rvalid = 0; e_err = 0; e_rdata = '0; e_rid = '0; e_irq = 0;
        end else begin
            tpop  = (txq.size() != 0) && tx_ready;
            rpush = rx_valid && (rxq.size() < DEPTH);
            tpush = 0; rpop = 0; tclr = 0; rclr = 0; terr = 0; rd = '0;
            off = int'(addr[11:2]);
            if (req) begin
                if (off == 0 && we) begin
                    if (be != 4'hF || txq.size() == DEPTH) terr = 1; else tpush = 1;
                end else if (off == 0) begin
                    if (rxq.size() == 0) terr = 1;
                    else begin rpop = 1; rd = rxq[0]; end
                end else if (off == 1 && !we) begin
                    rd = (rxq.size() << 16) | (txq.size() << 8);
                    if (txq.size() == DEPTH) rd = rd + 1;
                    if (txq.size() == 0)     rd = rd + 2;
                    if (rxq.size() == DEPTH) rd = rd + 4;
                    if (rxq.size() == 0)     rd = rd + 8;
                end else if (off == 2 && we) begin
                    tclr = wdata[0]; rclr = wdata[1]; m_irq_en = wdata[8];
                end else if (off == 2) begin
                    rd = m_irq_en ? 32'h100 : 32'h0;
                end else begin
                    terr = 1;
                end
            end
            if (tclr) txq.delete();
            else begin
                if (tpop)  void'(txq.pop_front());
                if (tpush) txq.push_back(wdata);
            end
            if (rclr) rxq.delete();
            else begin
                if (rpop)  void'(rxq.pop_front());
                if (rpush) rxq.push_back(rx_data);
            end
            e_rvalid = req; e_err = terr; e_rdata = rd; e_rid = aid;
            e_irq = m_irq_en && (rxq.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("gnt", gnt, 1);
            check("rvalid", rvalid, e_rvalid);
            if (e_rvalid) begin
                check("err", err, e_err);
                check("rdata", rdata, e_rdata);
                check("rid", rid, e_rid);
            end
            check("tx_valid", tx_valid, txq.size() != 0);
            if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
            check("rx_ready", rx_ready, rxq.size() < DEPTH);
            check("irq", irq, e_irq);
        end
    end

    // Directed stimulus; every task is entered and left at a falling edge.
    logic        r_valid, r_err;
    logic [31:0] r_rdata;
    logic [0:0]  r_rid;
    logic [31:0] got[$];

    task automatic obi(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [0:0] id);
        req = 1; we = w; addr = a; wdata = d; be = b; aid = id;
        @(negedge clk);
        req = 0; we = 0;
        r_valid = rvalid; r_err = err; r_rdata = rdata; r_rid = rid;
    endtask

    task automatic rx_send(input logic [31:0] d);
        rx_valid = 1; rx_data = d;
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic drain();
        got.delete();
        tx_ready = 1;
        for (int i = 0; i < 20 && tx_valid; i++) begin
            got.push_back(tx_data);
            @(negedge clk);
        end
        tx_ready = 0;
        check("tx_drained", tx_valid, 0);
    endtask

    localparam logic [31:0] BASE = 32'h2000_0000;

    initial begin
        logic [31:0] exp4 [4];
        exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;

        repeat (3) @(negedge clk);
        check("rst_rvalid", rvalid, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rid", rid, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_irq", irq, 0);
        rst = 0;
        @(negedge clk);

        obi(0, BASE + 4, 0, 4'hF, 0);
        check("status_reset", r_rdata, 32'h0000_000A);
        check("status_reset_err", r_err, 0);
        obi(0, BASE + 8, 0, 4'hF, 0);
        check("ctrl_reset", r_rdata, 0);

        for (int i = 0; i < 4; i++) begin
            obi(1, BASE, exp4[i], 4'hF, 0);
            check("tx_wr_ok", r_err, 0);
        end
        obi(1, BASE, 32'h55, 4'hF, 0);
        check("tx_wr_full_err", r_err, 1);
        obi(0, BASE + 4, 0, 4'hF, 0);
        check("status_tx_full", r_rdata, 32'h0000_0409);
        drain();
        check("tx_drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("tx_drain_data", got[i], exp4[i]);

        rx_send(32'hA0);
        rx_send(32'hA1);
        check("irq_disabled", irq, 0);
        obi(1, BASE + 8, 32'h100, 4'hF, 0);
        check("irq_on", irq, 1);
        obi(0, BASE, 0, 4'hF, 0);
        check("rx_pop0", r_rdata, 32'hA0);
        check("irq_still_on", irq, 1);
        obi(0, BASE, 0, 4'hF, 0);
        check("rx_pop1", r_rdata, 32'hA1);
        check("irq_off", irq, 0);
        obi(0, BASE, 0, 4'hF, 0);
        check("rx_empty_err", r_err, 1);
        check("rx_empty_rdata", r_rdata, 0);

        obi(0, BASE + 4, 0, 4'hF, 0);
        check("b2b_v0", r_valid, 1); check("b2b_id0", r_rid, 0);
        obi(0, BASE + 4, 0, 4'hF, 1);
        check("b2b_v1", r_valid, 1); check("b2b_id1", r_rid, 1);
        obi(0, BASE + 4, 0, 4'hF, 0);
        check("b2b_v2", r_valid, 1); check("b2b_id2", r_rid, 0);
        @(negedge clk);
        check("b2b_idle", rvalid, 0);
        obi(1, BASE + 32'h10, 32'h1, 4'hF, 0);
        check("unmapped_err", r_err, 1);
        obi(1, BASE + 4, 32'h1, 4'hF, 0);
        check("status_wr_err", r_err, 1);
        obi(1, BASE, 32'h77, 4'h3, 0);
        check("partial_be_err", r_err, 1);
        check("partial_be_tx_empty", tx_valid, 0);

        for (int i = 1; i <= 4; i++) obi(1, BASE, i, 4'hF, 0);
        tx_ready = 1;
        obi(1, BASE, 32'h99, 4'hF, 0);
        tx_ready = 0;
        check("full_pop_wr_err", r_err, 1);
        obi(0, BASE + 4, 0, 4'hF, 0);
        check("status_lvl3", r_rdata, 32'h0000_0308);
        drain();
        check("no99_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) check("no99_data", got[i], i + 2);

        rx_send(32'hB0);
        rx_send(32'hB1);
        rx_valid = 1; rx_data = 32'hB2;
        obi(1, BASE + 8, 32'h2, 4'hF, 0);
        rx_valid = 0;
        obi(0, BASE + 4, 0, 4'hF, 0);
        check("rx_clear_status", r_rdata, 32'h0000_000A);

        obi(1, BASE + 8, 32'h100, 4'hF, 0);
        obi(1, BASE, 32'h77, 4'hF, 0);
        rx_send(32'hC0);
        check("pre_rst_irq", irq, 1);
        rst = 1; rx_valid = 1; rx_data = 32'hC1;
        req = 1; we = 0; addr = BASE + 4; aid = 1;
        @(negedge clk);
        req = 0; rx_valid = 0;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_rid", rid, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_rx_ready", rx_ready, 1);
        check("mid_rst_irq", irq, 0);
        rst = 0;
        obi(0, BASE + 4, 0, 4'hF, 0);
        check("post_rst_status", r_rdata, 32'h0000_000A);
        obi(0, BASE + 8, 0, 4'hF, 0);
        check("post_rst_ctrl", r_rdata, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
